// File: rtl/clkdiv_pkg.sv
// Shared constants for the transmit serializer clock-divider chain.
`timescale 1ps/1fs
package clkdiv_pkg;

   // Divided-output count limits; the upper bound keeps the counter within one halfword.
   localparam int unsigned CLKDIV_STAGES_MIN = 1;
   localparam int unsigned CLKDIV_STAGES_MAX = 16;

   // Behavioural clock-to-output delay shared with the tx serializer cells (ps).
   localparam real CLKDIV_T_CLKQ_DEF = 5.0;

endpackage

// File: rtl/clkdiv.sv
// Divides clkin into STAGES clocks of clkin/2^(i+1), all launched from falling clkin edges.
// A synchronous binary counter drives every output, so bits change together with zero skew.
`timescale 1ps/1fs
module clkdiv
   import clkdiv_pkg::*;
#(
   parameter int unsigned STAGES = 4,
   parameter real         T_CLKQ = CLKDIV_T_CLKQ_DEF
) (
   input  logic              clkin,
   input  logic              rst,
   output logic [STAGES-1:0] clkout
);

   logic [STAGES-1:0] cnt_q;
   logic [STAGES-1:0] cnt_d;

   // Wrap from all-ones to zero is the natural modulo-2^STAGES overflow.
   always_comb begin
      cnt_d = cnt_q + {{(STAGES-1){1'b0}}, 1'b1};
   end

   always_ff @(negedge clkin or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flop Q straight to the pins: only a delay model, never a gate after the register.
   assign #(T_CLKQ) clkout = cnt_q;

endmodule

// File: tb/tb_clkdiv.sv
// Bench for clkdiv: cycle model, edge timing/duty measurement and a 32:1 serializer tree.
`timescale 1ps/1fs
module tb_clkdiv;

   localparam real HALF = 62.5;
   localparam real TCQ  = 5.0;

   logic       clkin = 1'b1;
   logic       rst   = 1'b1;
   logic [3:0] clkout;
   logic [0:0] clkout1;

   int errors = 0;
   int checks = 0;

   clkdiv #(.STAGES(4), .T_CLKQ(TCQ)) u_dut4 (
      .clkin  (clkin),
      .rst    (rst),
      .clkout (clkout)
   );

   clkdiv #(.STAGES(1), .T_CLKQ(TCQ)) u_dut1 (
      .clkin  (clkin),
      .rst    (rst),
      .clkout (clkout1)
   );

   // Falling edges at 62.5, 187.5, ... ps: odd multiples of a half period.
   always #(HALF) clkin = ~clkin;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $realtime);
      end
   endtask

   task automatic chkr(input string nm, input real act, input real exp);
      checks++;
      if ((act - exp > 0.01) || (exp - act > 0.01)) begin
         errors++;
         $display("FAIL %s: got %f expected %f at %0t", nm, act, exp, $realtime);
      end
   endtask

   // Model: n = falling clkin edges since reset released; bit i is the parity of n / 2^i.
   int n = 0;
   always @(negedge clkin) begin
      if (rst) n = 0;
      else     n = n + 1;
   end

   function automatic logic [3:0] model_out(input int cnt, input int nbits);
      logic [3:0] v;
      v = '0;
      for (int i = 0; i < nbits; i++) v[i] = ((cnt / (1 << i)) % 2) == 1;
      return v;
   endfunction

   bit chk_en = 1'b0;
   always @(posedge clkin) begin
      if (chk_en) begin
         chk("model_stages4", {28'd0, clkout},  {28'd0, (rst ? 4'd0 : model_out(n, 4))});
         chk("model_stages1", {31'd0, clkout1}, {31'd0, (rst ? 1'b0 : model_out(n, 1)) & 1'b1});
      end
   end

   // Edge measurement window: timing alignment, period, duty and toggle counts.
   bit meas_en = 1'b0;
   int toggles [4];
   int nper [4];
   int toggles1 = 0;

   function automatic real align_err(input real t);
      real k;
      k = (t - TCQ - HALF) / (2.0 * HALF);
      return k - real'($rtoi(k + 0.5));
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_mon
      realtime t_rise, t_fall;
      bit      have_rise = 1'b0;
      bit      have_fall = 1'b0;
      always @(clkout[g]) begin
         if (!meas_en) begin
            have_rise = 1'b0;
            have_fall = 1'b0;
         end else begin
            toggles[g]++;
            chkr($sformatf("edge_align_bit%0d", g), align_err($realtime), 0.0);
            if (clkout[g]) begin
               if (have_rise) begin
                  nper[g]++;
                  chkr($sformatf("period_bit%0d", g), $realtime - t_rise, 250.0 * (1 << g));
                  if (have_fall)
                     chkr($sformatf("high_bit%0d", g), t_fall - t_rise, 125.0 * (1 << g));
               end
               t_rise    = $realtime;
               have_rise = 1'b1;
            end else begin
               t_fall    = $realtime;
               have_fall = 1'b1;
            end
         end
      end
   end

   always @(clkout1[0]) begin
      if (meas_en) begin
         toggles1++;
         chkr("edge_align_s1", align_err($realtime), 0.0);
      end
   end

   // Serializer tree: select = {clkout[3:0], clkin}, word loaded on falling clkout[3].
   logic [31:0] words [17];
   logic [31:0] cur_word;
   bit          ser_on = 1'b0;
   int          widx   = 0;
   int          bitk   = 32;

   always @(negedge clkout[3]) begin
      if (ser_on && widx < 17) begin
         cur_word = words[widx];
         widx++;
         bitk = 0;
      end
   end

   always @(clkin) begin
      #(HALF / 2.0);
      if (ser_on && bitk < 32) begin
         logic [4:0] sel;
         sel = {clkout, clkin};
         chk($sformatf("ser_w%0d_b%0d", widx - 1, bitk), {31'd0, cur_word[sel]}, {31'd0, cur_word[bitk]});
         bitk++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete by %0t", $realtime);
      $fatal(1, "watchdog");
   end

   initial begin
      chk_en = 1'b1;
      // Reset hold with clkin running.
      repeat (5) begin
         @(posedge clkin);
         #1;
         chk("reset_hold", {28'd0, clkout}, 32'd0);
      end
      #9 rst = 1'b0;

      // First falling edge: clkout[0] rises exactly T_CLKQ later.
      @(negedge clkin);
      #4;
      chk("before_tclkq", {28'd0, clkout}, 32'd0);
      #2;
      chk("first_rise",    {28'd0, clkout},  32'd1);
      chk("first_rise_s1", {31'd0, clkout1}, 32'd1);

      // Advance to cnt = 11 and reset between edges.
      repeat (10) @(negedge clkin);
      @(posedge clkin);
      #20;
      chk("cnt_1011", {28'd0, clkout}, 32'hb);
      rst = 1'b1;
      #6;
      chk("async_rst",    {28'd0, clkout},  32'd0);
      chk("async_rst_s1", {31'd0, clkout1}, 32'd0);
      repeat (3) @(posedge clkin);
      #10 rst = 1'b0;
      @(negedge clkin);
      #10;
      chk("restart",    {28'd0, clkout},  32'd1);
      chk("restart_s1", {31'd0, clkout1}, 32'd1);

      // Frequency, duty and wrap over 512 falling edges (32 full counter wraps).
      @(posedge clkin);
      meas_en = 1'b1;
      repeat (512) @(negedge clkin);
      #20;
      meas_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("toggles_bit%0d", i), toggles[i], 512 >> i);
         chk($sformatf("periods_ge16_bit%0d", i), {31'd0, nper[i] >= 16}, 32'd1);
      end
      chk("toggles_s1", toggles1, 512);

      // Serializer integration: all ones, then 16 random words.
      words[0] = 32'hffff_ffff;
      for (int k = 1; k < 17; k++) words[k] = $urandom;
      ser_on = 1'b1;
      for (int c = 0; c < 1000 && !(widx == 17 && bitk == 32); c++) @(posedge clkin);
      chk("ser_done", {31'd0, (widx == 17 && bitk == 32)}, 32'd1);
      ser_on = 1'b0;
      chk_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
